online_operand_feeder: RTL and testbench
========================================

// Module: online_operand_feeder
// PURPOSE
//  Source end of the multiplier's enable_for_input handshake: holds two parallel
//  radix-2 signed-digit operands and emits them MSB-first, one digit pair per
//  consumed enable.
//  Pads DELTA zero digits for the online delay, then drives cnt_master to the
//  computation control / CA_RAM sequencing. Double-buffered so the next
//  operand pair loads while the current one streams.
// PARAMETERS
//  N_DIGITS  32  digits per operand (>=2)
//  DELTA     3   online delay; zero digits appended after the operand
//  CNT_W     9   width of cnt_master
//  IDX_W     6   width of digit_idx; must hold N_DIGITS+DELTA-1
// PORTS
//  clk               in   1         rising-edge clock
//  rst_n             in   1         asynchronous active-low reset
//  in_valid          in   1         operand pair offered
//  in_ready          out  1         operand pair accepted when in_valid & in_ready
//  x_pos, x_neg      in   N_DIGITS  X digit planes; bit N_DIGITS-1 = MSD
//  y_pos, y_neg      in   N_DIGITS  Y digit planes; same layout
//  enable_for_input  in   1         multiplier consumes current digits this cycle
//  x_digit, y_digit  out  2         {plus,minus}: 10=+1, 01=-1, 00=0; never 11
//  digit_valid       out  1         x_digit/y_digit meaningful
//  digit_idx         out  IDX_W     index of presented digit, 0 = MSD
//  cnt_master        out  CNT_W     cycle count since operand launch
//  busy              out  1         FEED or FLUSH
//  done              out  1         one-cycle pulse after last flush digit consumed
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE, pending empty.
//   All shift regs, digit_idx, cnt_master = 0; in_ready=1; digit_valid, busy, done = 0.
//   Asserting reset mid-stream aborts it and drops any pending pair. No done pulse.
//  Digit encode: a pos/neg pair with both bits set is emitted as 00. Value 0 is
//   encoded only as 00.
//  consume = digit_valid & enable_for_input. enable_for_input is ignored otherwise.
//  FSM: IDLE -> FEED -> FLUSH -> DONE -> (IDLE | FEED).
//   IDLE: in_ready=1. On accept, load shift regs, digit_idx=0, cnt_master=0 -> FEED.
//   FEED: digits = shift-reg MSBs; digit_valid=1.
//    consume: shift left one, digit_idx+1.
//    consume at digit_idx==N_DIGITS-1 -> FLUSH.
//   FLUSH: digits=00, digit_valid=1. Each consume: digit_idx+1.
//    consume at digit_idx==N_DIGITS+DELTA-1 -> DONE.
//   DONE: one cycle. done=1, digit_valid=0.
//    If pending full: load pending into shift regs, clear pending, digit_idx=0,
//     cnt_master=0 -> FEED.
//    Else -> IDLE.
//  Latency: first digit is valid the cycle after accept. Without stalls a pair
//   takes N_DIGITS+DELTA consume cycles, plus 1 DONE cycle.
//  Pending buffer:
//   In FEED/FLUSH/DONE, in_ready = ~pending_full; an accept fills pending.
//   In DONE with pending full, in_ready=0 that cycle (no same-cycle refill).
//   An accept in DONE with pending empty fills pending. The FSM then goes to
//    IDLE; IDLE with pending full launches next cycle, same as an IDLE accept.
//  cnt_master: +1 every clk in FEED and FLUSH (stalls included).
//   Saturates at 2^CNT_W-1. Holds in IDLE/DONE. Cleared on every launch.
//  digit_idx holds its value during stalls. Outputs are registered; no combinational in->out paths.
// STRUCTURE
//  Shared package/header `online_mult_defs`:
//   - SD_POS=2'b10, SD_NEG=2'b01, SD_ZERO=2'b00
//   - state encodings FEED_IDLE/FEED/FLUSH/DONE
//   - default N_DIGITS/DELTA
//  Sub-module sd_shift_reg (N_DIGITS-wide pos/neg pair, load/shift/MSB encode)
//   Instantiated twice, for X and Y.
//  The FSM, pending buffer and counters live in the top module.
// TESTING
//  T1 reset: rst_n low, in_valid=1 -> in_ready=1, digit_valid=0, cnt_master=0, done=0 throughout.
//  T2 stream:
//   N=32, DELTA=3, enable_for_input=1 always, X=+1 at MSD only, Y all 0.
//   -> x_digit=10 at idx0, then 00.
//   -> 35 valid cycles, done at cycle 36, cnt_master=35 at done.
//  T3 stall: drop enable_for_input for 5 cycles at idx 10.
//   -> digit_idx/digits frozen at 10; cnt_master still +5; done 5 cycles later than T2.
//  T4 back-to-back:
//   Offer 2nd pair during FEED -> accepted (pending), in_ready low.
//   3rd pair refused until the 2nd launches from DONE.
//   2nd pair's idx0 appears the cycle after done; no IDLE gap.
//  T5 encode edge: pos=neg=1 at idx0, neg-only at idx1 -> digits 00 then 01; 11 never observed.
//  T6 abort: assert rst_n low at idx 20 with pending full.
//   -> all outputs at reset values; after release, IDLE with no stale launch.

Source files
------------

// File: rtl/online_operand_feeder_pkg.sv
// Shared definitions for the online multiplier operand path: signed-digit codes,
// feeder state encoding and default operand geometry.
package online_operand_feeder_pkg;

    localparam int DEF_N_DIGITS = 32;
    localparam int DEF_DELTA    = 3;

    localparam logic [1:0] SD_POS  = 2'b10;
    localparam logic [1:0] SD_NEG  = 2'b01;
    localparam logic [1:0] SD_ZERO = 2'b00;

    typedef enum logic [1:0] {
        FEED_IDLE = 2'd0,
        FEED      = 2'd1,
        FLUSH     = 2'd2,
        DONE      = 2'd3
    } feed_state_e;

    // A digit with both planes set is a redundant zero and leaves as 00.
    function automatic logic [1:0] sd_encode(input logic pos, input logic neg);
        case ({pos, neg})
            2'b10:   return SD_POS;
            2'b01:   return SD_NEG;
            default: return SD_ZERO;
        endcase
    endfunction

endpackage

// File: rtl/online_operand_feeder_if.sv
// Operand-load handshake plus the digit stream toward the online multiplier.
// master = the feeder, slave = the operand producer / digit consumer side.
interface online_operand_feeder_if #(
    parameter int N_DIGITS = 32,
    parameter int CNT_W    = 9,
    parameter int IDX_W    = 6
);
    logic                in_valid;
    logic                in_ready;
    logic [N_DIGITS-1:0] x_pos;
    logic [N_DIGITS-1:0] x_neg;
    logic [N_DIGITS-1:0] y_pos;
    logic [N_DIGITS-1:0] y_neg;
    logic                enable_for_input;
    logic [1:0]          x_digit;
    logic [1:0]          y_digit;
    logic                digit_valid;
    logic [IDX_W-1:0]    digit_idx;
    logic [CNT_W-1:0]    cnt_master;
    logic                busy;
    logic                done;

    modport master (
        input  in_valid, x_pos, x_neg, y_pos, y_neg, enable_for_input,
        output in_ready, x_digit, y_digit, digit_valid, digit_idx, cnt_master, busy, done
    );

    modport slave (
        output in_valid, x_pos, x_neg, y_pos, y_neg, enable_for_input,
        input  in_ready, x_digit, y_digit, digit_valid, digit_idx, cnt_master, busy, done
    );
endinterface

// File: rtl/online_operand_feeder_sd_shift_reg.sv
// One signed-digit operand held as pos/neg planes, shifted out MSD-first.
// Zeros shift in from the bottom, so the flush phase reads 00 for free.
module sd_shift_reg
    import online_operand_feeder_pkg::*;
#(
    parameter int N_DIGITS = DEF_N_DIGITS
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load_i,
    input  logic                shift_i,
    input  logic [N_DIGITS-1:0] pos_i,
    input  logic [N_DIGITS-1:0] neg_i,
    output logic [1:0]          digit_o
);
    logic [N_DIGITS-1:0] pos_q, neg_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_q <= '0;
            neg_q <= '0;
        end else if (load_i) begin
            pos_q <= pos_i;
            neg_q <= neg_i;
        end else if (shift_i) begin
            pos_q <= {pos_q[N_DIGITS-2:0], 1'b0};
            neg_q <= {neg_q[N_DIGITS-2:0], 1'b0};
        end
    end

    assign digit_o = sd_encode(pos_q[N_DIGITS-1], neg_q[N_DIGITS-1]);
endmodule

// File: rtl/online_operand_feeder.sv
// Streams a double-buffered pair of signed-digit operands MSD-first into the
// online multiplier, pads DELTA zero digits and counts cycles since launch.
module online_operand_feeder
    import online_operand_feeder_pkg::*;
#(
    parameter int N_DIGITS = DEF_N_DIGITS,
    parameter int DELTA    = DEF_DELTA,
    parameter int CNT_W    = 9,
    parameter int IDX_W    = 6
) (
    input  logic                    clk,
    input  logic                    rst_n,
    online_operand_feeder_if.master bus
);
    localparam logic [IDX_W-1:0] LAST_FEED  = IDX_W'(N_DIGITS - 1);
    localparam logic [IDX_W-1:0] LAST_FLUSH = IDX_W'(N_DIGITS + DELTA - 1);

    feed_state_e         state_q, state_d;
    logic                pend_q, pend_d;
    logic [N_DIGITS-1:0] pxp_q, pxn_q, pyp_q, pyn_q;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                load, load_pend, shift, cap;
    logic                streaming, accept, consume;

    assign streaming = (state_q == FEED) || (state_q == FLUSH);
    assign accept    = bus.in_valid & ~pend_q;
    assign consume   = streaming & bus.enable_for_input;

    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        load      = 1'b0;
        load_pend = 1'b0;
        shift     = 1'b0;
        cap       = 1'b0;
        if (streaming && cnt_q != {CNT_W{1'b1}})
            cnt_d = cnt_q + 1'b1;
        case (state_q)
            FEED_IDLE: begin
                if (pend_q) begin
                    load      = 1'b1;
                    load_pend = 1'b1;
                    pend_d    = 1'b0;
                    state_d   = FEED;
                end else if (accept) begin
                    load    = 1'b1;
                    state_d = FEED;
                end
            end
            FEED: begin
                if (accept) begin
                    cap    = 1'b1;
                    pend_d = 1'b1;
                end
                if (consume) begin
                    shift = 1'b1;
                    idx_d = idx_q + 1'b1;
                    if (idx_q == LAST_FEED) state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (accept) begin
                    cap    = 1'b1;
                    pend_d = 1'b1;
                end
                // The final index is held rather than wrapped past the counter range.
                if (consume) begin
                    if (idx_q == LAST_FLUSH) state_d = DONE;
                    else                     idx_d   = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (pend_q) begin
                    load      = 1'b1;
                    load_pend = 1'b1;
                    pend_d    = 1'b0;
                    state_d   = FEED;
                end else begin
                    if (accept) begin
                        cap    = 1'b1;
                        pend_d = 1'b1;
                    end
                    state_d = FEED_IDLE;
                end
            end
            default: state_d = FEED_IDLE;
        endcase
        if (load) begin
            idx_d = '0;
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FEED_IDLE;
            pend_q  <= 1'b0;
            idx_q   <= '0;
            cnt_q   <= '0;
            pxp_q   <= '0;
            pxn_q   <= '0;
            pyp_q   <= '0;
            pyn_q   <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            if (cap) begin
                pxp_q <= bus.x_pos;
                pxn_q <= bus.x_neg;
                pyp_q <= bus.y_pos;
                pyn_q <= bus.y_neg;
            end
        end
    end

    sd_shift_reg #(.N_DIGITS(N_DIGITS)) u_x (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (load),
        .shift_i (shift),
        .pos_i   (load_pend ? pxp_q : bus.x_pos),
        .neg_i   (load_pend ? pxn_q : bus.x_neg),
        .digit_o (bus.x_digit)
    );

    sd_shift_reg #(.N_DIGITS(N_DIGITS)) u_y (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (load),
        .shift_i (shift),
        .pos_i   (load_pend ? pyp_q : bus.y_pos),
        .neg_i   (load_pend ? pyn_q : bus.y_neg),
        .digit_o (bus.y_digit)
    );

    assign bus.in_ready    = ~pend_q;
    assign bus.digit_valid = streaming;
    assign bus.busy        = streaming;
    assign bus.done        = (state_q == DONE);
    assign bus.digit_idx   = idx_q;
    assign bus.cnt_master  = cnt_q;
endmodule

// File: tb/tb_online_operand_feeder.sv
// Bench for online_operand_feeder: table vectors, hand-written corner sequences and
// random traffic, all checked every cycle against a queue-based reference model.
module tb_online_operand_feeder;
    localparam int N    = 32;
    localparam int D    = 3;
    localparam int CW   = 9;
    localparam int IW   = 6;
    localparam int CMAX = (1 << CW) - 1;

    typedef struct {
        logic [N-1:0] xp, xn, yp, yn;
    } pair_t;

    typedef struct {
        logic [N-1:0] xp, xn, yp, yn;
        logic [1:0]   x0, x1, y0, y1;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    online_operand_feeder_if #(.N_DIGITS(N), .CNT_W(CW), .IDX_W(IW)) bus();

    online_operand_feeder #(.N_DIGITS(N), .DELTA(D), .CNT_W(CW), .IDX_W(IW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    int total  = 0;
    int passed = 0;

    // Reference model: the pair being streamed, the digit it presents, cycles since
    // launch, whether it is in its done cycle, and accepted pairs not yet launched.
    bit    have_cur, in_done;
    pair_t cur;
    int    k, cyc;
    pair_t waitq[$];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    endtask

    function automatic logic [1:0] ref_dig(input logic [N-1:0] p, input logic [N-1:0] n, input int idx);
        int v;
        if (idx >= N) return 2'b00;
        v = int'(p[N-1-idx]) - int'(n[N-1-idx]);
        if (v > 0) return 2'b10;
        if (v < 0) return 2'b01;
        return 2'b00;
    endfunction

    function automatic void model_reset();
        have_cur = 0; in_done = 0; k = 0; cyc = 0;
        waitq.delete();
    endfunction

    function automatic void launch(input pair_t p);
        cur = p; have_cur = 1; k = 0; cyc = 0;
    endfunction

    function automatic void model_update();
        pair_t inp;
        bit    acc;
        inp = '{bus.x_pos, bus.x_neg, bus.y_pos, bus.y_neg};
        acc = bus.in_valid && (waitq.size() == 0);
        if (in_done) begin
            in_done = 0;
            if (waitq.size() > 0) launch(waitq.pop_front());
            else have_cur = 0;
            if (acc) waitq.push_back(inp);
        end else if (have_cur) begin
            if (cyc < CMAX) cyc++;
            if (acc) waitq.push_back(inp);
            if (bus.enable_for_input) begin
                if (k == N + D - 1) in_done = 1;
                else k++;
            end
        end else begin
            if (waitq.size() > 0) launch(waitq.pop_front());
            else if (acc) launch(inp);
        end
    endfunction

    task automatic model_compare();
        bit v;
        v = have_cur && !in_done;
        chk("in_ready", int'(bus.in_ready), int'(waitq.size() == 0));
        chk("digit_valid", int'(bus.digit_valid), int'(v));
        chk("busy", int'(bus.busy), int'(v));
        chk("done", int'(bus.done), int'(in_done));
        chk("cnt_master", int'(bus.cnt_master), cyc);
        if (v) begin
            chk("digit_idx", int'(bus.digit_idx), k);
            chk("x_digit", int'(bus.x_digit), int'(ref_dig(cur.xp, cur.xn, k)));
            chk("y_digit", int'(bus.y_digit), int'(ref_dig(cur.yp, cur.yn, k)));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_update();
        @(negedge clk);
        if (rst_n) model_compare();
    endtask

    task automatic set_pair(input pair_t p);
        bus.x_pos = p.xp; bus.x_neg = p.xn; bus.y_pos = p.yp; bus.y_neg = p.yn;
    endtask

    function automatic pair_t rand_pair();
        pair_t p;
        p.xp = $urandom; p.xn = $urandom; p.yp = $urandom; p.yn = $urandom;
        return p;
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, int'(bus.in_ready), 1);
        chk({tag, "_digit_valid"}, int'(bus.digit_valid), 0);
        chk({tag, "_busy"}, int'(bus.busy), 0);
        chk({tag, "_done"}, int'(bus.done), 0);
        chk({tag, "_cnt"}, int'(bus.cnt_master), 0);
        chk({tag, "_idx"}, int'(bus.digit_idx), 0);
        chk({tag, "_x_digit"}, int'(bus.x_digit), 0);
    endtask

    // Launches one pair from idle, stalls enable at stall_idx for stall_len cycles,
    // and reports cycle numbers counted from the accepting edge.
    task automatic run_stream(input pair_t p, input int stall_idx, input int stall_len,
                              output int nv, output int done_at, output int cnt_done,
                              output logic [1:0] x0, output logic [1:0] x1,
                              output logic [1:0] y0, output logic [1:0] y1);
        int stalled;
        set_pair(p);
        bus.in_valid = 1; bus.enable_for_input = 1;
        tick();
        bus.in_valid = 0;
        nv = 0; done_at = -1; cnt_done = -1; stalled = 0;
        x0 = 2'b11; x1 = 2'b11; y0 = 2'b11; y1 = 2'b11;
        for (int c = 1; c <= 800; c++) begin
            if (bus.digit_valid) begin
                nv++;
                if (bus.digit_idx == 0) begin x0 = bus.x_digit; y0 = bus.y_digit; end
                if (bus.digit_idx == 1) begin x1 = bus.x_digit; y1 = bus.y_digit; end
            end
            if (bus.done) begin
                done_at = c; cnt_done = int'(bus.cnt_master);
                break;
            end
            if (have_cur && k == stall_idx && stalled < stall_len) begin
                bus.enable_for_input = 0; stalled++;
            end else begin
                bus.enable_for_input = 1;
            end
            tick();
        end
        if (done_at < 0) chk("stream_timeout", 0, 1);
        bus.enable_for_input = 1;
        tick();
    endtask

    task automatic drain();
        bit idle;
        bus.in_valid = 0; bus.enable_for_input = 1;
        idle = 0;
        for (int c = 0; c < 600; c++) begin
            if (!have_cur && waitq.size() == 0) begin idle = 1; break; end
            tick();
        end
        if (!idle) chk("drain_timeout", 0, 1);
        tick();
    endtask

    vec_t  vecs[4];
    pair_t p;
    int    nv, done_at, cnt_done;
    logic [1:0] x0, x1, y0, y1;
    bit    found;

    initial begin
        vecs[0] = '{32'h8000_0000, 32'h0, 32'h0, 32'h0, 2'b10, 2'b00, 2'b00, 2'b00};
        vecs[1] = '{32'h8000_0000, 32'hC000_0000, 32'h4000_0000, 32'h0, 2'b00, 2'b01, 2'b00, 2'b10};
        vecs[2] = '{32'hFFFF_FFFF, 32'h0, 32'h0, 32'hFFFF_FFFF, 2'b10, 2'b10, 2'b01, 2'b01};
        vecs[3] = '{32'h4000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b01, 2'b10, 2'b00, 2'b00};

        // Reset with a pair offered: nothing may be accepted or launched.
        set_pair(rand_pair());
        bus.in_valid = 1; bus.enable_for_input = 1;
        #1 rst_n = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_reset_outputs("reset");
        end
        model_reset();
        bus.in_valid = 0;
        rst_n = 1;
        tick();

        for (int i = 0; i < 4; i++) begin
            p = '{vecs[i].xp, vecs[i].xn, vecs[i].yp, vecs[i].yn};
            run_stream(p, -1, 0, nv, done_at, cnt_done, x0, x1, y0, y1);
            chk($sformatf("vec%0d_x0", i), int'(x0), int'(vecs[i].x0));
            chk($sformatf("vec%0d_x1", i), int'(x1), int'(vecs[i].x1));
            chk($sformatf("vec%0d_y0", i), int'(y0), int'(vecs[i].y0));
            chk($sformatf("vec%0d_y1", i), int'(y1), int'(vecs[i].y1));
            if (i == 0) begin
                chk("stream_valid_cycles", nv, 35);
                chk("stream_done_cycle", done_at, 36);
                chk("stream_cnt_at_done", cnt_done, 35);
            end
        end

        p = '{vecs[0].xp, vecs[0].xn, vecs[0].yp, vecs[0].yn};
        run_stream(p, 10, 5, nv, done_at, cnt_done, x0, x1, y0, y1);
        chk("stall_valid_cycles", nv, 40);
        chk("stall_done_cycle", done_at, 41);
        chk("stall_cnt_at_done", cnt_done, 40);

        run_stream(rand_pair(), 0, 520, nv, done_at, cnt_done, x0, x1, y0, y1);
        chk("sat_done_cycle", done_at, 556);
        chk("sat_cnt_at_done", cnt_done, CMAX);

        // Back-to-back: second pair pends, third waits for the second to launch.
        set_pair(rand_pair()); bus.in_valid = 1; bus.enable_for_input = 1;
        tick();
        bus.in_valid = 0;
        repeat (5) tick();
        set_pair(rand_pair()); bus.in_valid = 1;
        tick();
        set_pair(rand_pair());
        chk("b2b_ready_pending", int'(bus.in_ready), 0);
        found = 0;
        for (int c = 0; c < 100; c++) begin
            if (bus.done) begin found = 1; break; end
            tick();
        end
        chk("b2b_done_seen", int'(found), 1);
        chk("b2b_ready_in_done", int'(bus.in_ready), 0);
        tick();
        chk("b2b_no_gap_valid", int'(bus.digit_valid), 1);
        chk("b2b_no_gap_idx", int'(bus.digit_idx), 0);
        chk("b2b_ready_after_launch", int'(bus.in_ready), 1);
        tick();
        chk("b2b_third_accepted", int'(bus.in_ready), 0);
        drain();

        // Abort mid-stream with a pair pending.
        set_pair(rand_pair()); bus.in_valid = 1; bus.enable_for_input = 1;
        tick();
        set_pair(rand_pair());
        tick();
        bus.in_valid = 0;
        found = 0;
        for (int c = 0; c < 100; c++) begin
            if (have_cur && !in_done && k == 20) begin found = 1; break; end
            tick();
        end
        chk("abort_reached_idx20", int'(found), 1);
        chk("abort_pending_full", int'(bus.in_ready), 0);
        #2 rst_n = 0;
        #1 check_reset_outputs("abort");
        model_reset();
        tick();
        rst_n = 1;
        repeat (4) tick();
        chk("abort_no_stale_launch", int'(bus.busy), 0);

        for (int c = 0; c < 400; c++) begin
            bus.in_valid = ($urandom_range(0, 3) == 0);
            bus.enable_for_input = ($urandom_range(0, 4) != 0);
            set_pair(rand_pair());
            tick();
        end
        drain();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
